// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction/data requests onto a single-ported RAM, data first
// Ports: CLK/RST (sync, active-high); iREN/iaddr instruction request; dREN/dWEN/daddr/dstore data request;
// ihit/iload, dhit/dload one-cycle completion strobes with load data; ramREN/ramWEN/ramaddr/ramstore
// drive the RAM, ramload/ramstate come back from it; err is the sticky failure flag.
// Define MEM_ARB_PERF_EN to add saturating icount/dcount completion counters.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
`endif
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, INSTR = 3'd2, DONE = 3'd3, FAIL = 3'd4;
  localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;
  logic [2:0]        state;
  logic              h_data, h_wen;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_store, load_q;
  logic [CW-1:0]     cnt, cnt_nxt;
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    ramREN   = state == INSTR || (state == DATA && !h_wen);
    ramWEN   = state == DATA && h_wen;
    ramaddr  = (state == DATA || state == INSTR) ? h_addr : '0;
    ramstore = (state == DATA && h_wen) ? h_store : '0;
    ihit     = state == DONE && !h_data;
    dhit     = state == DONE && h_data;
    iload    = (state == DONE && !h_data) ? load_q : '0;
    dload    = (state == DONE && h_data) ? load_q : '0;
    err      = state == FAIL;
  end
  // DONE always returns to IDLE, so a request level still high on the hit edge is never re-granted.
  // The counter compare fires on the wait that would make it equal TIMEOUT_CYC, so it never wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      h_data  <= 1'b0;
      h_wen   <= 1'b0;
      h_addr  <= '0;
      h_store <= '0;
      load_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE:
          if (dREN || dWEN) begin
            state   <= DATA;
            h_data  <= 1'b1;
            h_wen   <= dWEN;
            h_addr  <= daddr;
            h_store <= dWEN ? dstore : '0;
            cnt     <= '0;
          end else if (iREN) begin
            state   <= INSTR;
            h_data  <= 1'b0;
            h_wen   <= 1'b0;
            h_addr  <= iaddr;
            h_store <= '0;
            cnt     <= '0;
          end
        DATA, INSTR:
          if (ramstate == ACCESS) begin
            state  <= DONE;
            load_q <= h_wen ? '0 : ramload;
          end else if (ramstate == ERROR || cnt_nxt == CW'(TIMEOUT_CYC)) begin
            state <= FAIL;
          end else begin
            cnt <= cnt_nxt;
          end
        DONE: state <= IDLE;
        default: state <= FAIL;
      endcase
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else if (state == DONE) begin
      icount <= (!h_data && !(&icount)) ? icount + 1'b1 : icount;
      dcount <= (h_data && !(&dcount)) ? dcount + 1'b1 : dcount;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        iren = 1'b0, dren = 1'b0, dwen = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ram_load = '0;
  logic [1:0]  ram_state = 2'd0;
  logic        ihit, dhit, ram_ren, ram_wen, err;
  logic [31:0] iload, dload, ram_addr, ram_store;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] icount, dcount;
  logic [31:0] m_icnt = '0, m_dcnt = '0;
`endif
  int errors = 0, checks = 0;
  bit armed = 1'b0;
  bit m_fail, m_txn, m_kind, m_wr, m_hit, m_hkind;
  logic [31:0] m_addr, m_wdata, m_hval;
  int m_waits = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  bit saw_i, saw_d;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RST(rst), .iREN(iren), .iaddr(iaddr), .dREN(dren), .dWEN(dwen),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr), .ramstore(ram_store),
    .ramload(ram_load), .ramstate(ram_state),
`ifdef MEM_ARB_PERF_EN
    .icount(icount), .dcount(dcount),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  // Transaction-level reference: one outstanding request, data before instruction,
  // a hit cycle after ACCESS, a guard cycle after every hit, sticky failure.
  always @(posedge clk) begin
    armed <= armed | rst;
    if (rst) begin
      m_fail <= 0; m_txn <= 0; m_hit <= 0; m_waits <= 0;
`ifdef MEM_ARB_PERF_EN
      m_icnt <= '0; m_dcnt <= '0;
`endif
    end else if (m_fail) begin
      m_hit <= 0;
    end else if (m_hit) begin
      m_hit <= 0;
`ifdef MEM_ARB_PERF_EN
      if (m_hkind) m_dcnt <= (m_dcnt == 32'hFFFFFFFF) ? m_dcnt : m_dcnt + 1;
      else m_icnt <= (m_icnt == 32'hFFFFFFFF) ? m_icnt : m_icnt + 1;
`endif
    end else if (m_txn) begin
      if (ram_state == 2'd2) begin
        m_hit <= 1; m_hkind <= m_kind; m_hval <= m_wr ? 32'h0 : ram_load; m_txn <= 0;
      end else if (ram_state == 2'd3 || m_waits + 1 == TO) begin
        m_fail <= 1; m_txn <= 0;
      end else m_waits <= m_waits + 1;
    end else if (dren || dwen) begin
      m_txn <= 1; m_kind <= 1; m_wr <= dwen; m_addr <= daddr; m_wdata <= dstore; m_waits <= 0;
    end else if (iren) begin
      m_txn <= 1; m_kind <= 0; m_wr <= 0; m_addr <= iaddr; m_waits <= 0;
    end
  end

  always @(posedge clk)
    if (!rst && ram_wen && ram_state == 2'd2) begin
      wr_addr <= ram_addr;
      wr_data <= ram_store;
    end

  always @(negedge clk)
    if (armed) begin
      chk("ihit", ihit, m_hit && !m_hkind);
      chk("dhit", dhit, m_hit && m_hkind);
      chk("iload", iload, (m_hit && !m_hkind) ? m_hval : 32'h0);
      chk("dload", dload, (m_hit && m_hkind) ? m_hval : 32'h0);
      chk("ramREN", ram_ren, m_txn && !m_wr);
      chk("ramWEN", ram_wen, m_txn && m_wr);
      chk("err", err, m_fail);
      if (m_txn) chk("ramaddr", ram_addr, m_addr);
      if (m_txn && m_wr) chk("ramstore", ram_store, m_wdata);
`ifdef MEM_ARB_PERF_EN
      chk("icount", icount, m_icnt);
      chk("dcount", dcount, m_dcnt);
`endif
    end

  task automatic do_xfer(input bit d, input bit w, input logic [31:0] a, input logic [31:0] v);
    bit got = 0;
    if (d) begin dren = !w; dwen = w; daddr = a; dstore = v; end
    else begin iren = 1; iaddr = a; end
    ram_state = 2'd2; ram_load = v;
    for (int k = 0; k < 8 && !got; k++) begin
      mid;
      if (d ? dhit : ihit) got = 1;
      cyc;
    end
    chk("xfer_hit", got, 1);
    iren = 0; dren = 0; dwen = 0; ram_state = 2'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    iren = 1; iaddr = 32'h1234;
    cyc; mid;
    chk("rst_enables", {ram_ren, ram_wen, ihit, dhit, err}, 0);
    chk("rst_buses", iload | dload | ram_addr | ram_store, 0);
    cyc; rst = 0; mid;
    chk("rst_enables2", {ram_ren, ram_wen, ihit, dhit, err}, 0);
    cyc; mid;
    chk("rst_exit_ren", ram_ren, 1);
    chk("rst_exit_addr", ram_addr, 32'h1234);
    ram_state = 2'd2; ram_load = 32'h11;
    cyc; mid;
    chk("rst_fetch_iload", iload, 32'h11);
    cyc; iren = 0; ram_state = 2'd0;

    iren = 1; iaddr = 32'h40; ram_state = 2'd1;
    cyc; mid;
    chk("fetch_ren", ram_ren, 1);
    chk("fetch_addr", ram_addr, 32'h40);
    cyc; cyc; cyc;
    ram_state = 2'd2; ram_load = 32'h2408000A;
    mid;
    chk("fetch_nohit_yet", ihit, 0);
    cyc; mid;
    chk("fetch_ihit", ihit, 1);
    chk("fetch_iload", iload, 32'h2408000A);
    chk("fetch_dhit", dhit, 0);
    cyc; iren = 0; ram_state = 2'd0; mid;
    chk("fetch_ihit_drop", ihit, 0);
    chk("guard_ren", ram_ren, 0);
    cyc; mid;
    chk("guard_ren2", ram_ren, 0);

    iren = 1; iaddr = 32'h44; dwen = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ram_state = 2'd1;
    cyc; mid;
    chk("cont_wen", ram_wen, 1);
    chk("cont_ren", ram_ren, 0);
    chk("cont_addr", ram_addr, 32'h100);
    chk("cont_store", ram_store, 32'hDEADBEEF);
    cyc; daddr = 32'h200; dstore = 32'h12345678; mid;
    chk("hold_addr", ram_addr, 32'h100);
    chk("hold_store", ram_store, 32'hDEADBEEF);
    ram_state = 2'd2;
    cyc; mid;
    chk("cont_dhit", dhit, 1);
    chk("cont_dload", dload, 0);
    chk("cont_ihit", ihit, 0);
    chk("ram_wr_addr", wr_addr, 32'h100);
    chk("ram_wr_data", wr_data, 32'hDEADBEEF);
    cyc; dwen = 0; ram_state = 2'd1; mid;
    chk("cont_gap", {ram_ren, ram_wen}, 0);
    cyc; mid;
    chk("cont_iren", ram_ren, 1);
    chk("cont_iaddr", ram_addr, 32'h44);
    ram_state = 2'd2; ram_load = 32'hCAFEF00D;
    cyc; mid;
    chk("cont_ihit2", ihit, 1);
    chk("cont_iload", iload, 32'hCAFEF00D);
    cyc; iren = 0; ram_state = 2'd0;

    dren = 1; daddr = 32'h80; ram_state = 2'd1;
    cyc;
    for (int k = 1; k <= 4; k++) begin
      cyc; mid;
      chk("timeout_err", err, k == 4);
    end
    chk("timeout_ren", ram_ren, 0);
    ram_state = 2'd2;
    cyc; cyc; mid;
    chk("timeout_sticky", err, 1);
    chk("timeout_nohit", dhit, 0);
    rst = 1; cyc; rst = 0; mid;
    chk("timeout_rst_clear", err, 0);
    ram_state = 2'd3;
    cyc; cyc; mid;
    chk("error_err", err, 1);
    rst = 1; dren = 0; cyc; rst = 0; ram_state = 2'd0;

    iren = 1; iaddr = 32'h88; ram_state = 2'd1;
    cyc; cyc; rst = 1; ram_state = 2'd2;
    cyc; rst = 0; iren = 0; mid;
    chk("midrst_nohit", ihit, 0);
    chk("midrst_ren", ram_ren, 0);
    cyc; ram_state = 2'd0;

`ifdef MEM_ARB_PERF_EN
    for (int n = 0; n < 5; n++) do_xfer(0, 0, 32'h400 + n, $urandom);
    for (int n = 0; n < 3; n++) do_xfer(1, n[0], 32'h800 + n, $urandom);
    mid;
    chk("perf_icount", icount, 5);
    chk("perf_dcount", dcount, 3);
    rst = 1; cyc; rst = 0; mid;
    chk("perf_rst", icount | dcount, 0);
`else
    do_xfer(0, 0, 32'h400, 32'h5);
    do_xfer(1, 1, 32'h800, 32'h6);
`endif

    for (int n = 0; n < 4000; n++) begin
      mid;
      saw_i = ihit; saw_d = dhit;
      cyc;
      if (saw_i) iren = 0;
      if (saw_d) begin dren = 0; dwen = 0; end
      if (!iren && $urandom_range(3) == 0) begin iren = 1; iaddr = $urandom; end
      if (!dren && !dwen && $urandom_range(4) == 0) begin
        int r = $urandom_range(2);
        dren = r != 1; dwen = r != 0; daddr = $urandom; dstore = $urandom;
      end
      if ($urandom_range(7) == 0) begin daddr = $urandom; dstore = $urandom; iaddr = $urandom; end
      begin
        int r = $urandom_range(39);
        ram_state = (r == 0) ? 2'd3 : (r < 20) ? 2'd2 : (r < 30) ? 2'd1 : 2'd0;
      end
      ram_load = $urandom;
      rst = (m_fail && $urandom_range(3) == 0) || $urandom_range(199) == 0;
    end
    cyc; rst = 0; iren = 0; dren = 0; dwen = 0; ram_state = 2'd0;
    cyc; cyc; mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
